// File: rtl/ship_pkg.sv
// rtl/ship_pkg.sv - shared state encoding, Q1.16 unit and width helpers for the ship controller
package ship_pkg;

    typedef enum logic [2:0] {
        ALIVE        = 3'd0,
        EXPLODING    = 3'd1,
        INVULNERABLE = 3'd2,
        GAME_OVER    = 3'd3
    } ship_state_t;

    localparam int ONE = 65536;

    function automatic int vel_w(input int vmax);
        return $clog2(vmax) + 2;
    endfunction

    // Room for one screen span of underflow/overflow before the wrap correction.
    function automatic int pos_w(input int size, input int frac);
        return $clog2(size) + frac + 2;
    endfunction

endpackage

// File: rtl/ship_ctrl_unit_if.sv
// rtl/ship_ctrl_unit_if.sv - control inputs and drawer-facing outputs of the ship controller
interface ship_ctrl_unit_if
    import ship_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int VMAX   = 1024,
    parameter int LIVES  = 3
);
    logic                           frame_tick;
    logic                           thrust;
    logic                           collision;
    logic                           restart;
    logic signed [17:0]             sin_val;
    logic signed [17:0]             cos_val;
    logic [$clog2(WIDTH)-1:0]       center_x;
    logic [$clog2(HEIGHT)-1:0]      center_y;
    logic signed [vel_w(VMAX)-1:0]  vel_x;
    logic signed [vel_w(VMAX)-1:0]  vel_y;
    logic                           visible;
    logic                           alive;
    logic [$clog2(LIVES+1)-1:0]     lives_left;
    logic [2:0]                     state;

    modport master (
        output frame_tick, thrust, collision, restart, sin_val, cos_val,
        input  center_x, center_y, vel_x, vel_y, visible, alive, lives_left, state
    );

    modport slave (
        input  frame_tick, thrust, collision, restart, sin_val, cos_val,
        output center_x, center_y, vel_x, vel_y, visible, alive, lives_left, state
    );

endinterface

// File: rtl/ship_axis_integrator.sv
// rtl/ship_axis_integrator.sv - one axis of velocity/position integration with wrap; SHIP_DRAG_EN adds drag
module ship_axis_integrator
    import ship_pkg::*;
#(
    parameter int SIZE       = 640,
    parameter int FRAC       = 8,
    parameter int VMAX       = 1024,
    parameter int DRAG_SHIFT = 6,
    localparam int VW        = vel_w(VMAX),
    localparam int PW        = pos_w(SIZE, FRAC),
    localparam int CW        = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic signed [VW-1:0] accel,
    input  logic                 thrust,
    input  logic                 step,
    input  logic                 clear_vel,
    input  logic                 recentre,
    output logic signed [VW-1:0] vel,
    output logic [CW-1:0]        center
);

`ifdef SHIP_DRAG_EN
    localparam bit DRAG_ON = 1'b1;
`else
    localparam bit DRAG_ON = 1'b0;
`endif

    localparam logic signed [PW-1:0] SPAN  = PW'(SIZE << FRAC);
    localparam logic signed [PW-1:0] HOME  = PW'((SIZE / 2) << FRAC);
    localparam logic signed [VW:0]   VLIM  = (VW + 1)'(VMAX);
    localparam logic signed [VW:0]   NVLIM = -VLIM;
    localparam logic signed [VW-1:0] VPOS  = VW'(VMAX);
    localparam logic signed [VW-1:0] VNEG  = -VPOS;
    localparam logic signed [VW-1:0] DMIN  = VW'(1 << DRAG_SHIFT);
    localparam logic signed [VW-1:0] NDMIN = -DMIN;

    logic signed [VW-1:0] vel_q, vel_d;
    logic signed [PW-1:0] pos_q, pos_d;
    logic [CW-1:0]        center_q, center_d;
    logic                 pos_step_q, pos_step_d;
    logic signed [VW:0]   vel_sum;
    logic signed [VW-1:0] drag;
    logic signed [PW-1:0] pos_sum;

    always_comb begin
        vel_sum    = {vel_q[VW-1], vel_q} + {accel[VW-1], accel};
        drag       = vel_q - (vel_q >>> DRAG_SHIFT);
        pos_sum    = pos_q + {{(PW - VW){vel_q[VW-1]}}, vel_q};
        vel_d      = vel_q;
        pos_d      = pos_q;
        pos_step_d = 1'b0;
        center_d   = CW'(pos_q >>> FRAC);

        if (recentre) begin
            vel_d = '0;
            pos_d = HOME;
        end else if (clear_vel) begin
            vel_d = '0;
        end else if (step) begin
            pos_step_d = 1'b1;
            if (thrust) begin
                if (vel_sum > VLIM)       vel_d = VPOS;
                else if (vel_sum < NVLIM) vel_d = VNEG;
                else                      vel_d = vel_sum[VW-1:0];
            end else if (DRAG_ON) begin
                // Snap small residues to zero so the truncating shift cannot creep forever.
                if (drag < DMIN && drag > NDMIN) vel_d = '0;
                else                             vel_d = drag;
            end
        end

        // Position integrates the velocity produced one cycle earlier.
        if (!recentre && pos_step_q) begin
            if (pos_sum[PW-1])       pos_d = pos_sum + SPAN;
            else if (pos_sum >= SPAN) pos_d = pos_sum - SPAN;
            else                      pos_d = pos_sum;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vel_q      <= '0;
            pos_q      <= HOME;
            center_q   <= CW'(SIZE / 2);
            pos_step_q <= 1'b0;
        end else begin
            vel_q      <= vel_d;
            pos_q      <= pos_d;
            center_q   <= center_d;
            pos_step_q <= pos_step_d;
        end
    end

    assign vel    = vel_q;
    assign center = center_q;

endmodule

// File: rtl/ship_ctrl_unit.sv
// rtl/ship_ctrl_unit.sv - ship motion and life-cycle controller top; optional drag under SHIP_DRAG_EN
module ship_ctrl_unit
    import ship_pkg::*;
#(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int FRAC           = 8,
    parameter int THRUST_SHIFT   = 10,
    parameter int VMAX           = 1024,
    parameter int DRAG_SHIFT     = 6,
    parameter int LIVES          = 3,
    parameter int EXPLODE_FRAMES = 60,
    parameter int INVULN_FRAMES  = 120
) (
    input  logic            clk,
    input  logic            resetN,
    ship_ctrl_unit_if.slave bus
);

    localparam int VW      = vel_w(VMAX);
    localparam int CNT_MAX = (EXPLODE_FRAMES > INVULN_FRAMES) ? EXPLODE_FRAMES : INVULN_FRAMES;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam int LW      = $clog2(LIVES + 1);

    ship_state_t          state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]        lives_q, lives_d;
    logic                 visible_q, visible_d;
    logic                 alive_q, alive_d;
    logic                 moving, hit, recentre, step;
    logic signed [17:0]   ax_full, ay_full;
    logic signed [VW-1:0] accel_x, accel_y;

    // Heading 0 points up, so cosine drives negative y.
    always_comb begin
        ax_full = bus.sin_val >>> THRUST_SHIFT;
        ay_full = -(bus.cos_val >>> THRUST_SHIFT);
        accel_x = VW'(ax_full);
        accel_y = VW'(ay_full);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lives_d  = lives_q;
        hit      = 1'b0;
        recentre = 1'b0;
        moving   = (state_q == ALIVE) || (state_q == INVULNERABLE);

        case (state_q)
            ALIVE: begin
                if (bus.collision) begin
                    hit     = 1'b1;
                    state_d = EXPLODING;
                    cnt_d   = CNTW'(EXPLODE_FRAMES);
                    lives_d = lives_q - 1'b1;
                end
            end
            EXPLODING: begin
                if (bus.frame_tick) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNTW'(1)) begin
                        if (lives_q == '0) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d  = INVULNERABLE;
                            cnt_d    = CNTW'(INVULN_FRAMES);
                            recentre = 1'b1;
                        end
                    end
                end
            end
            INVULNERABLE: begin
                if (bus.frame_tick) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNTW'(1)) state_d = ALIVE;
                end
            end
            GAME_OVER: begin
                if (bus.restart) begin
                    state_d  = INVULNERABLE;
                    cnt_d    = CNTW'(INVULN_FRAMES);
                    lives_d  = LW'(LIVES);
                    recentre = 1'b1;
                end
            end
            default: begin
                state_d = INVULNERABLE;
                cnt_d   = CNTW'(INVULN_FRAMES);
            end
        endcase

        // A hit on the tick cycle cancels that frame's motion entirely.
        step = bus.frame_tick && moving && !hit;

        case (state_d)
            ALIVE:        visible_d = 1'b1;
            INVULNERABLE: visible_d = cnt_d[3];
            default:      visible_d = 1'b0;
        endcase
        alive_d = (state_d == ALIVE) || (state_d == INVULNERABLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= INVULNERABLE;
            cnt_q     <= CNTW'(INVULN_FRAMES);
            lives_q   <= LW'(LIVES);
            visible_q <= 1'b1;
            alive_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lives_q   <= lives_d;
            visible_q <= visible_d;
            alive_q   <= alive_d;
        end
    end

    ship_axis_integrator #(
        .SIZE(WIDTH), .FRAC(FRAC), .VMAX(VMAX), .DRAG_SHIFT(DRAG_SHIFT)
    ) u_axis_x (
        .clk(clk), .resetN(resetN), .accel(accel_x), .thrust(bus.thrust), .step(step),
        .clear_vel(hit), .recentre(recentre), .vel(bus.vel_x), .center(bus.center_x)
    );

    ship_axis_integrator #(
        .SIZE(HEIGHT), .FRAC(FRAC), .VMAX(VMAX), .DRAG_SHIFT(DRAG_SHIFT)
    ) u_axis_y (
        .clk(clk), .resetN(resetN), .accel(accel_y), .thrust(bus.thrust), .step(step),
        .clear_vel(hit), .recentre(recentre), .vel(bus.vel_y), .center(bus.center_y)
    );

    assign bus.state      = state_q;
    assign bus.lives_left = lives_q;
    assign bus.visible    = visible_q;
    assign bus.alive      = alive_q;

endmodule

// File: tb/tb_ship_ctrl_unit.sv
// tb/tb_ship_ctrl_unit.sv - directed self-checking bench for ship_ctrl_unit
module tb_ship_ctrl_unit;
    import ship_pkg::*;

`ifdef SHIP_DRAG_EN
    localparam bit DRAG = 1'b1;
`else
    localparam bit DRAG = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   glitches = 0;
    bit   mon_en = 1'b0;

    ship_ctrl_unit_if #(.WIDTH(640), .HEIGHT(480), .VMAX(1024), .LIVES(3)) bus ();

    ship_ctrl_unit dut (.clk(clk), .resetN(resetN), .bus(bus.slave));

    always #5 clk = ~clk;

    always @(negedge clk) if (mon_en && bus.center_x > 10'd639) glitches++;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.frame_tick = 1'b1;
            @(negedge clk) bus.frame_tick = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic pulse_collision();
        @(negedge clk) bus.collision = 1'b1;
        @(negedge clk) bus.collision = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_restart();
        @(negedge clk) bus.restart = 1'b1;
        @(negedge clk) bus.restart = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int px, vx, exp_cx, prev_cx, cx0, cy0;
        bit wrapped;
        bus.frame_tick = 1'b0;
        bus.thrust     = 1'b0;
        bus.collision  = 1'b0;
        bus.restart    = 1'b0;
        bus.sin_val    = 18'sd0;
        bus.cos_val    = 18'(ONE);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        check("rst_state", int'(bus.state), int'(INVULNERABLE));
        check("rst_lives", int'(bus.lives_left), 3);
        check("rst_visible", int'(bus.visible), 1);
        check("rst_alive", int'(bus.alive), 1);
        check("rst_cx", int'(bus.center_x), 320);
        check("rst_cy", int'(bus.center_y), 240);
        check("rst_vx", int'(bus.vel_x), 0);
        check("rst_vy", int'(bus.vel_y), 0);

        tick(1);
        check("blink_t1", int'(bus.visible), 0);
        tick(8);
        check("blink_t9", int'(bus.visible), 1);
        pulse_collision();
        check("inv_coll_state", int'(bus.state), int'(INVULNERABLE));
        check("inv_coll_lives", int'(bus.lives_left), 3);
        pulse_restart();
        check("restart_ignored", int'(bus.state), int'(INVULNERABLE));
        tick(110);
        check("t119_state", int'(bus.state), int'(INVULNERABLE));
        check("t119_visible", int'(bus.visible), 0);
        tick(1);
        check("t120_state", int'(bus.state), int'(ALIVE));
        check("t120_visible", int'(bus.visible), 1);
        check("t120_cx", int'(bus.center_x), 320);
        check("t120_cy", int'(bus.center_y), 240);

        bus.thrust = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            check("up_vy", int'(bus.vel_y), -64 * k);
            check("up_vx", int'(bus.vel_x), 0);
            check("up_cy", int'(bus.center_y), (k == 3) ? 238 : 239);
        end

        bus.sin_val = 18'(ONE);
        bus.cos_val = 18'sd0;
        px = 320 * 256;
        vx = 0;
        prev_cx = 320;
        wrapped = 1'b0;
        mon_en = 1'b1;
        for (int i = 1; i <= 95; i++) begin
            tick(1);
            vx = (vx + 64 > 1024) ? 1024 : vx + 64;
            px = px + vx;
            if (px >= 640 * 256) px = px - 640 * 256;
            exp_cx = px / 256;
            check("right_vx", int'(bus.vel_x), vx);
            check("right_cx", int'(bus.center_x), exp_cx);
            if (int'(bus.center_x) < prev_cx) wrapped = 1'b1;
            prev_cx = int'(bus.center_x);
        end
        mon_en = 1'b0;
        check("wrap_seen", int'(wrapped), 1);
        check("cx_in_range", glitches, 0);
        check("vy_held", int'(bus.vel_y), -192);

        bus.thrust = 1'b0;
        cx0 = int'(bus.center_x);
        cy0 = int'(bus.center_y);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        bus.collision  = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.collision  = 1'b0;
        repeat (4) @(negedge clk);
        check("hit_state", int'(bus.state), int'(EXPLODING));
        check("hit_lives", int'(bus.lives_left), 2);
        check("hit_vx", int'(bus.vel_x), 0);
        check("hit_vy", int'(bus.vel_y), 0);
        check("hit_visible", int'(bus.visible), 0);
        check("hit_alive", int'(bus.alive), 0);
        check("hit_cx", int'(bus.center_x), cx0);
        check("hit_cy", int'(bus.center_y), cy0);
        tick(59);
        check("exp59_state", int'(bus.state), int'(EXPLODING));
        check("exp59_visible", int'(bus.visible), 0);
        tick(1);
        check("exp60_state", int'(bus.state), int'(INVULNERABLE));
        check("exp60_cx", int'(bus.center_x), 320);
        check("exp60_cy", int'(bus.center_y), 240);
        check("exp60_visible", int'(bus.visible), 1);

        tick(120);
        check("life2_alive", int'(bus.state), int'(ALIVE));
        pulse_collision();
        check("hit2_lives", int'(bus.lives_left), 1);
        tick(60);
        tick(120);
        check("life1_alive", int'(bus.state), int'(ALIVE));
        pulse_collision();
        check("hit3_lives", int'(bus.lives_left), 0);
        check("hit3_state", int'(bus.state), int'(EXPLODING));
        tick(60);
        check("go_state", int'(bus.state), int'(GAME_OVER));
        check("go_visible", int'(bus.visible), 0);
        check("go_alive", int'(bus.alive), 0);
        tick(2);
        pulse_collision();
        check("go_hold", int'(bus.state), int'(GAME_OVER));
        pulse_restart();
        check("rs_state", int'(bus.state), int'(INVULNERABLE));
        check("rs_lives", int'(bus.lives_left), 3);
        check("rs_cx", int'(bus.center_x), 320);
        check("rs_cy", int'(bus.center_y), 240);

        tick(120);
        bus.thrust = 1'b1;
        tick(16);
        check("sat_vx", int'(bus.vel_x), 1024);
        bus.thrust = 1'b0;
        tick(1);
        check("coast1_vx", int'(bus.vel_x), DRAG ? 1008 : 1024);
        tick(300);
        check("coast_end_vx", int'(bus.vel_x), DRAG ? 0 : 1024);
        check("coast_end_vy", int'(bus.vel_y), 0);

        pulse_collision();
        tick(10);
        @(negedge clk) resetN = 1'b0;
        #1;
        check("midreset_state", int'(bus.state), int'(INVULNERABLE));
        check("midreset_lives", int'(bus.lives_left), 3);
        check("midreset_cx", int'(bus.center_x), 320);
        check("midreset_visible", int'(bus.visible), 1);
        @(negedge clk) resetN = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
